ibex_icache_dm: RTL
===================

Name: ibex_icache_dm

Overview:
- Small direct-mapped, single-word-line instruction cache between the Ibex core instruction port and the instruction SRAM (req/gnt/rvalid protocol).
- Hits return in 1 cycle at up to one per cycle.
- Misses fetch one word from the SRAM and fill the line.
- flush_i (fence.i) invalidates all lines.

Parameters:
- SETS, 16, number of lines; power of 2, 2..512.
- ADDR_W, 10, SRAM word-address width; byte address bits [ADDR_W+1:2] are used.
- INDEX_W, $clog2(SETS), derived; not overridable.
- TAG_W, ADDR_W-INDEX_W, derived.

Ports:
- clk  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- instr_req_i  in  1  core fetch request.
- instr_gnt_o  out  1  request accepted this cycle.
- instr_addr_i  in  32  core byte address; [1:0] and [31:ADDR_W+2] ignored.
- instr_rvalid_o  out  1  response valid, one cycle wide.
- instr_rdata_o  out  32  response data.
- flush_i  in  1  invalidate all lines.
- sram_req_o  out  1  SRAM request.
- sram_gnt_i  in  1  SRAM grant.
- sram_addr_o  out  ADDR_W  SRAM word address.
- sram_rvalid_i  in  1  SRAM data valid.
- sram_rdata_i  in  32  SRAM data.
- hit_cnt_o  out  32  saturating count of granted hits.
- miss_cnt_o  out  32  saturating count of granted misses.

Behaviour:
- Address split:
  - idx = instr_addr_i[INDEX_W+1:2]
  - tag = instr_addr_i[ADDR_W+1:INDEX_W+2]
  - SRAM word address = instr_addr_i[ADDR_W+1:2]
- Storage per line: valid, tag[TAG_W], data[32]. Registers, no SRAM macro.
- FSM states: IDLE, MISS_REQ, MISS_WAIT.
- instr_gnt_o = instr_req_i & (state==IDLE) & ~flush_i. Combinational.
- hit = valid[idx] & tag_arr[idx]==tag, evaluated in the grant cycle.
- Granted hit at cycle t:
  - instr_rvalid_o=1 and instr_rdata_o=data[idx] in t+1 (registered).
  - State stays IDLE, so back-to-back hits stream at 1/cycle.
- Granted miss at cycle t:
  - Latch miss word address and idx/tag; go to MISS_REQ at t+1.
- MISS_REQ:
  - sram_req_o=1, sram_addr_o=latched address, both held stable until sram_gnt_i is sampled high.
  - On sram_gnt_i=1 go to MISS_WAIT; sram_req_o drops the next cycle (no second grant cycle).
- MISS_WAIT:
  - sram_req_o=0.
  - On sram_rvalid_i=1: write data/tag to the latched line, set valid unless killed, drive instr_rvalid_o=1 with instr_rdata_o=sram_rdata_i on the next cycle, return to IDLE.
- Miss timing against a toggling-grant SRAM:
  - core gnt t0, sram_req t1..t2, sram_gnt t2, sram_rvalid t3, instr_rvalid t4.
  - A new core grant is allowed in t4.
- At most one outstanding miss. No core grant in MISS_REQ or MISS_WAIT.
- sram_rvalid_i in IDLE or MISS_REQ is ignored (stale response after reset).
- flush_i:
  - All valid bits clear at the next edge. Grant is suppressed that cycle.
  - An already-registered hit response still completes.
  - Flush during MISS_REQ/MISS_WAIT sets a kill flag. The fill still returns data to the core but leaves the line invalid. The kill flag clears on return to IDLE.
- Counters: increment on the grant cycle (hit or miss), saturate at 0xFFFFFFFF, not cleared by flush.
- instr_rdata_o holds its last value when instr_rvalid_o=0.
- Reset (any time, including mid-miss): state IDLE, all valid=0, kill=0.
  - All outputs reset to 0: instr_rvalid_o, instr_rdata_o, sram_req_o, sram_addr_o, hit_cnt_o, miss_cnt_o.
  - Tag/data arrays are not reset.

Decomposition:
- Package ibex_icache_pkg: state typedef (IDLE/MISS_REQ/MISS_WAIT), CNT_W=32, default SETS/ADDR_W.
- Sub-module icache_line_array: valid/tag/data storage, combinational read by idx, single write port, flush-all; reset clears valid only.

Test Plan:
- Cold miss: reset, request addr 0x0000_0040 with SRAM word 0x10 = 0xDEADBEEF. Expect gnt t0, sram_req t1-t2 with sram_addr=0x010, instr_rvalid t4 with rdata 0xDEADBEEF, miss_cnt=1.
- Hit stream: after filling 0x40/0x44/0x48, hold req on those three addresses. Expect three grants on consecutive cycles, rvalid on three consecutive cycles with correct data, hit_cnt=3, sram_req never asserted.
- Conflict eviction (SETS=16): fill 0x040, then 0x080 (same idx 0, different tag). Access 0x040 again: expect a miss and sram_addr=0x010.
- Flush: fill 0x40, pulse flush_i, request 0x40. Expect a miss. Repeat with flush asserted during MISS_WAIT: data is still returned, and the next access to 0x40 misses.
- Reset mid-miss: assert rst_ni=0 in MISS_WAIT before sram_rvalid. Expect all outputs 0 and state IDLE; a late sram_rvalid is ignored (no instr_rvalid); the next request to the same address misses.
- Address aliasing: request 0x1000_0042. It must hit the line filled for 0x0000_0040 (upper bits and [1:0] ignored).

Source files
------------

// File: rtl/ibex_icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Contents:
//   icache_state_e - miss-handling FSM states
//   CNT_W          - width of the hit/miss statistics counters
//   SETS_DEF       - default number of cache lines
//   ADDR_W_DEF     - default SRAM word-address width
//   sat_inc()      - saturating increment used by the statistics counters
package ibex_icache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2
    } icache_state_e;

    localparam int unsigned CNT_W      = 32;
    localparam int unsigned SETS_DEF   = 16;
    localparam int unsigned ADDR_W_DEF = 10;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Line storage for the direct-mapped instruction cache.
// Each line holds a valid bit, a tag and one 32-bit instruction word.
// Ports:
//   clk, rst_ni              - clock, asynchronous active-low reset (clears valid bits only)
//   flush                    - clear every valid bit at the next edge (wins over a write)
//   rd_idx                   - combinational read index
//   rd_valid/rd_tag/rd_data  - contents of line rd_idx
//   wr_en/wr_idx             - single write port
//   wr_tag/wr_data/wr_valid  - values written into line wr_idx
module icache_line_array #(
    parameter int unsigned SETS    = 16,
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned TAG_W   = 6
) (
    input  logic               clk,
    input  logic               rst_ni,
    input  logic               flush,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [31:0]        rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_data,
    input  logic               wr_valid
);

    logic [SETS-1:0]  valid_r;
    logic [TAG_W-1:0] tag_r  [SETS];
    logic [31:0]      data_r [SETS];

    // Valid bits: the only reset state of the array; flush overrides a same-cycle fill.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r <= {SETS{1'b0}};
        end else begin
            if (wr_en) begin
                valid_r[wr_idx] <= wr_valid;
            end
            if (flush) begin
                valid_r <= {SETS{1'b0}};
            end
        end
    end

    // Tag and data payload; left unreset since valid gates every use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_idx]  <= wr_tag;
            data_r[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_data  = data_r[rd_idx];

endmodule

// File: rtl/ibex_icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache between the Ibex
// instruction port and an instruction SRAM (req/gnt/rvalid on both sides).
// Hits answer one cycle after the grant and can stream at one per cycle;
// a miss fetches a single word from the SRAM and fills the line.
// Ports:
//   clk, rst_ni                        - clock, asynchronous active-low reset
//   instr_req_i/instr_gnt_o            - core request / combinational grant
//   instr_addr_i                       - core byte address
//   instr_rvalid_o/instr_rdata_o       - registered core response
//   flush_i                            - invalidate all lines (fence.i)
//   sram_req_o/sram_gnt_i/sram_addr_o  - SRAM request channel (word address)
//   sram_rvalid_i/sram_rdata_i         - SRAM response channel
//   hit_cnt_o/miss_cnt_o               - saturating granted hit/miss counters
module ibex_icache_dm
    import ibex_icache_pkg::*;
#(
    parameter int unsigned SETS   = SETS_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              instr_req_i,
    output logic              instr_gnt_o,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_rvalid_o,
    output logic [31:0]       instr_rdata_o,
    input  logic              flush_i,
    output logic              sram_req_o,
    input  logic              sram_gnt_i,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic              sram_rvalid_i,
    input  logic [31:0]       sram_rdata_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int unsigned INDEX_W = $clog2(SETS);
    localparam int unsigned TAG_W   = ADDR_W - INDEX_W;

    icache_state_e        state_r, state_n;
    logic [INDEX_W-1:0]   idx_s;
    logic [TAG_W-1:0]     tag_s;
    logic [ADDR_W-1:0]    word_s;
    logic                 rd_valid_s;
    logic [TAG_W-1:0]     rd_tag_s;
    logic [31:0]          rd_data_s;
    logic                 gnt_s, hit_s, hit_gnt_s, miss_gnt_s, fill_s;
    logic                 kill_r;
    logic                 rvalid_r;
    logic [31:0]          rdata_r;
    logic                 sram_req_r;
    logic [ADDR_W-1:0]    sram_addr_r;
    logic [CNT_W-1:0]     hit_cnt_r, miss_cnt_r;
    logic                 unused_addr_s;

    assign idx_s  = instr_addr_i[INDEX_W+1:2];
    assign tag_s  = instr_addr_i[ADDR_W+1:INDEX_W+2];
    assign word_s = instr_addr_i[ADDR_W+1:2];
    assign unused_addr_s = ^{instr_addr_i[31:ADDR_W+2], instr_addr_i[1:0]};

    assign gnt_s      = instr_req_i & (state_r == IDLE) & ~flush_i;
    assign hit_s      = rd_valid_s & (rd_tag_s == tag_s);
    assign hit_gnt_s  = gnt_s & hit_s;
    assign miss_gnt_s = gnt_s & ~hit_s;
    // SRAM data is only accepted while actually waiting for it; stale
    // responses arriving in IDLE or MISS_REQ fall on the floor.
    assign fill_s     = (state_r == MISS_WAIT) & sram_rvalid_i;

    // The latched SRAM word address doubles as the fill line's index and tag.
    icache_line_array #(
        .SETS    (SETS),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_lines (
        .clk      (clk),
        .rst_ni   (rst_ni),
        .flush    (flush_i),
        .rd_idx   (idx_s),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_data  (rd_data_s),
        .wr_en    (fill_s),
        .wr_idx   (sram_addr_r[INDEX_W-1:0]),
        .wr_tag   (sram_addr_r[ADDR_W-1:INDEX_W]),
        .wr_data  (sram_rdata_i),
        .wr_valid (~(kill_r | flush_i))
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (miss_gnt_s) begin
                    state_n = MISS_REQ;
                end else begin
                    state_n = IDLE;
                end
            end
            MISS_REQ: begin
                if (sram_gnt_i) begin
                    state_n = MISS_WAIT;
                end else begin
                    state_n = MISS_REQ;
                end
            end
            MISS_WAIT: begin
                if (sram_rvalid_i) begin
                    state_n = IDLE;
                end else begin
                    state_n = MISS_WAIT;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Registered core response, SRAM request, kill flag and statistics.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_r    <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            sram_req_r  <= 1'b0;
            sram_addr_r <= {ADDR_W{1'b0}};
            kill_r      <= 1'b0;
            hit_cnt_r   <= {CNT_W{1'b0}};
            miss_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            rvalid_r <= hit_gnt_s | fill_s;

            if (hit_gnt_s) begin
                rdata_r <= rd_data_s;
            end else if (fill_s) begin
                rdata_r <= sram_rdata_i;
            end else begin
                rdata_r <= rdata_r;
            end

            // Request rises with the missing grant and drops right after the SRAM grant.
            if (miss_gnt_s) begin
                sram_req_r  <= 1'b1;
                sram_addr_r <= word_s;
            end else if ((state_r == MISS_REQ) && sram_gnt_i) begin
                sram_req_r  <= 1'b0;
            end else begin
                sram_req_r  <= sram_req_r;
            end

            // A flush seen while a miss is in flight keeps the filled line invalid.
            if (state_n == IDLE) begin
                kill_r <= 1'b0;
            end else if (flush_i && (state_r != IDLE)) begin
                kill_r <= 1'b1;
            end else begin
                kill_r <= kill_r;
            end

            if (hit_gnt_s) begin
                hit_cnt_r <= sat_inc(hit_cnt_r);
            end else begin
                hit_cnt_r <= hit_cnt_r;
            end

            if (miss_gnt_s) begin
                miss_cnt_r <= sat_inc(miss_cnt_r);
            end else begin
                miss_cnt_r <= miss_cnt_r;
            end
        end
    end

    assign instr_gnt_o    = gnt_s;
    assign instr_rvalid_o = rvalid_r;
    assign instr_rdata_o  = rdata_r;
    assign sram_req_o     = sram_req_r;
    assign sram_addr_o    = sram_addr_r;
    assign hit_cnt_o      = hit_cnt_r;
    assign miss_cnt_o     = miss_cnt_r;

endmodule
